// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and
// the helper that sizes the shared cycle counter.
package pll_sup_pkg;

    localparam logic [2:0] ST_HOLD      = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    typedef enum logic [2:0] {
        HOLD      = ST_HOLD,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RUN       = ST_RUN,
        FAIL      = ST_FAIL
    } state_e;

    // One counter serves all three timed phases, so it is sized for the longest.
    function automatic int cnt_width(input int rst_cycles, input int lock_timeout,
                                     input int stable_cycles);
        int m;
        m = rst_cycles;
        if (lock_timeout > m)  m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous status input; clears to 0
// under the synchronous reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer with lock timeout/retry, lock debounce and core reset release.
// Define PLL_LOCK_SUPERVISOR_LOSS_CNT_EN to implement the lock-loss counter.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 5000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int LOSS_W        = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               restart,
    input  logic                               pll_locked,
    output logic                               pll_rst,
    output logic                               sys_reset,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOSS_W-1:0]                  loss_cnt
);

    localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RET_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0] RETRY_MAX    = RET_W'(MAX_RETRIES);

    logic locked_s;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RET_W-1:0] retry_q, retry_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        if (restart) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q == RETRY_MAX) begin
                            state_d = FAIL;
                        end else begin
                            state_d = HOLD;
                            retry_d = retry_q + RET_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                FAIL: begin
                    state_d = FAIL;
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_rst_d   = (state_d == HOLD) || (state_d == FAIL);
        sys_reset_d = (state_d != RUN);
        ready_d     = (state_d == RUN);
        fail_d      = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
        end
    end

`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
    logic              loss_inc;
    logic [LOSS_W-1:0] loss_q, loss_d;

    // A restart on the same cycle as the loss takes precedence and is not counted.
    assign loss_inc = (state_q == RUN) && !locked_s && !restart;

    always_comb begin
        loss_d = loss_q;
        if (loss_inc && !(&loss_q)) begin
            loss_d = loss_q + LOSS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_q <= '0;
        end else begin
            loss_q <= loss_d;
        end
    end

    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif

    assign pll_rst   = pll_rst_q;
    assign sys_reset = sys_reset_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: a phase/timestamp reference model
// predicts every cycle's outputs; a separate monitor pops and compares them.
module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int LOSS_W        = 8;
    localparam int RET_W         = $clog2(MAX_RETRIES + 1);
    localparam int LOSS_MAX      = (1 << LOSS_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              restart = 1'b0;
    logic              pll_locked = 1'b0;
    logic              pll_rst, sys_reset, ready, fail;
    logic [RET_W-1:0]  retry_cnt;
    logic [LOSS_W-1:0] loss_cnt;

    always #10 clk = ~clk;

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .LOSS_W        (LOSS_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    typedef struct {
        bit pll_rst;
        bit sys_reset;
        bit ready;
        bit fail;
        int retry;
        int loss;
    } exp_t;

    typedef enum {P_HOLD, P_WAIT, P_STABLE, P_RUN, P_FAIL} phase_e;

    exp_t   exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: current phase plus the cycle it was entered; lock is seen two cycles late.
    phase_e ph = P_HOLD;
    int     cyc = 0;
    int     t0 = 0;
    int     retries = 0;
    int     losses = 0;
    bit     s1 = 1'b0;
    bit     s2 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic enter(input phase_e p);
        ph = p;
        t0 = cyc;
    endtask

    task automatic model(input bit r, input bit rs, input bit l);
        bit   seen;
        int   in_phase;
        exp_t e;
        seen = s2;
        cyc++;
        in_phase = cyc - t0;
        if (r) begin
            enter(P_HOLD);
            retries = 0;
            losses  = 0;
        end else if (rs) begin
            enter(P_HOLD);
            retries = 0;
        end else begin
            case (ph)
                P_HOLD:   if (in_phase == RST_CYCLES) enter(P_WAIT);
                P_WAIT: begin
                    if (seen) enter(P_STABLE);
                    else if (in_phase == LOCK_TIMEOUT) begin
                        if (retries == MAX_RETRIES) enter(P_FAIL);
                        else begin
                            retries++;
                            enter(P_HOLD);
                        end
                    end
                end
                P_STABLE: begin
                    if (!seen) enter(P_WAIT);
                    else if (in_phase == STABLE_CYCLES) enter(P_RUN);
                end
                P_RUN: begin
                    if (!seen) begin
                        enter(P_HOLD);
                        retries = 0;
                        if (losses < LOSS_MAX) losses++;
                    end
                end
                default: ;
            endcase
        end
        s2 = r ? 1'b0 : s1;
        s1 = r ? 1'b0 : l;
        e.pll_rst   = (ph == P_HOLD) || (ph == P_FAIL);
        e.sys_reset = (ph != P_RUN);
        e.ready     = (ph == P_RUN);
        e.fail      = (ph == P_FAIL);
        e.retry     = retries;
`ifdef PLL_LOCK_SUPERVISOR_LOSS_CNT_EN
        e.loss      = losses;
`else
        e.loss      = 0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit rs, input bit l);
        @(negedge clk);
        rst        = r;
        restart    = rs;
        pll_locked = l;
        model(r, rs, l);
    endtask

    task automatic run(input int n, input bit l);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, l);
    endtask

    // Monitor: compares each registered output set one edge after its inputs were applied.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pll_rst",   32'(pll_rst),   32'(e.pll_rst));
                check("sys_reset", 32'(sys_reset), 32'(e.sys_reset));
                check("ready",     32'(ready),     32'(e.ready));
                check("fail",      32'(fail),      32'(e.fail));
                check("retry_cnt", 32'(retry_cnt), 32'(e.retry));
                check("loss_cnt",  32'(loss_cnt),  32'(e.loss));
            end
        end
    end

    initial begin
        int d;
        int len;
        bit lvl;

        repeat (3) step(1'b1, 1'b0, 1'b0);

        // Nominal lock with random delay after pll_rst falls, then a loss and relock.
        for (int k = 0; k < 3; k++) begin
            d = $urandom_range(5, 40);
            step(1'b1, 1'b0, 1'b0);
            run(RST_CYCLES + d, 1'b0);
            run(20, 1'b1);
            run($urandom_range(1, 3), 1'b0);
            run(30, 1'b1);
        end

        // Debounce: short high burst, a one-cycle dip, then sustained lock.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0);
            run(RST_CYCLES + 10, 1'b0);
            run($urandom_range(2, STABLE_CYCLES - 2), 1'b1);
            run(1, 1'b0);
            run(20, 1'b1);
        end

        // Timeout through every retry into FAIL, then restart out of FAIL and lock.
        step(1'b1, 1'b0, 1'b0);
        run((MAX_RETRIES + 1) * (RST_CYCLES + LOCK_TIMEOUT) + 10, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(RST_CYCLES + 5, 1'b0);
        run(20, 1'b1);

        // Restart on the exact cycle the synchronised lock drops in RUN.
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        run(RST_CYCLES + 3, 1'b0);
        run(20, 1'b1);

        // Reset mid-sequence: during STABLE, then during RUN after a counted loss.
        step(1'b1, 1'b0, 1'b0);
        run(RST_CYCLES + 3, 1'b0);
        run(5, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(RST_CYCLES + 2, 1'b0);
        run(20, 1'b1);
        run(2, 1'b0);
        run(30, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run(5, 1'b1);

        // Random soak: lock toggles with random run lengths, occasional restart or reset.
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            len = (($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 60));
            lvl = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < len; i++) begin
                step(($urandom_range(0, 399) == 0), ($urandom_range(0, 149) == 0), lvl);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
